ex_alu_stage: RTL and testbench
===============================

Name: ex_alu_stage

Overview:
- Execute-stage sequencer between the decode/issue pipeline register and the ALU.
- Accepts one operation at a time over a valid/ready handshake.
- Holds the ALU operands stable through multi-cycle multiply/divide stalls.
- Captures the ALU result into an output register that feeds the memory/writeback stage over a second valid/ready handshake.

Parameters:
ALU_OP_WID, 19, one-hot ALU operation width (bit 12..14 multiply, 15..18 divide/modulo)
DEST_WID, 5, destination register index width
PC_WID, 32, instruction PC width carried alongside the result

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-low
flush  input  1  kill the operation held in the EX slot (not the output register)
in_valid  input  1  issue request
in_ready  output  1  stage can accept an operation this cycle
in_alu_op  input  ALU_OP_WID  one-hot operation
in_src1  input  32  operand 1
in_src2  input  32  operand 2
in_dest  input  DEST_WID  destination register
in_pc  input  PC_WID  instruction PC
alu_op  output  ALU_OP_WID  operation to ALU; all-zero when not in EXEC
alu_src1  output  32  operand 1 to ALU
alu_src2  output  32  operand 2 to ALU
alu_result  input  32  ALU result
alu_stall  input  1  ALU busy; result not valid this cycle
out_valid  output  1  output register holds a result
out_ready  input  1  downstream consumes the result
out_result  output  32  result
out_dest  output  DEST_WID  destination
out_pc  output  PC_WID  PC

Behaviour:
- Reset is asynchronous, active-low on rstn: state=IDLE, out_valid=0, out_result/out_dest/out_pc=0, slot registers=0, alu_op=0.
- States: IDLE (slot empty), EXEC (slot driving ALU), HOLD (result latched locally, waiting on output register).
- out_free = !out_valid | out_ready.
- done = (state==EXEC) & !alu_stall.
- in_ready = (state==IDLE) | (done & out_free) | (state==HOLD & out_ready).
- Accept (in_valid & in_ready): load the slot with op/src1/src2/dest/pc; next state=EXEC.
- EXEC:
  - alu_op=slot op, alu_src1/2=slot operands, stable every cycle until the state is left.
  - done & out_free: load the output register; next state EXEC if accepting, else IDLE.
  - done & !out_free: latch alu_result into hold_result; next state HOLD.
  - Holding the op past completion is forbidden because the ALU multiply-stall toggle would restart.
- HOLD:
  - alu_op=0.
  - out_ready: move hold_result/dest/pc into the output register (out_valid stays 1); accept a new op in the same cycle.
- Output register:
  - out_valid clears on out_ready when no new result is loaded.
  - Load and drain in the same cycle leave out_valid=1 with the new data.
- Latency: single-cycle ops produce out_valid the cycle after accept. Multiply produces out_valid 2 cycles after accept. Divide produces out_valid 1 cycle after alu_stall falls.
- alu_stall is honoured in EXEC regardless of op. After a flush mid-divide the ALU stalls the next op until the divider drains; the stage simply waits.
- flush:
  - Forces state to IDLE next cycle and drops slot/hold contents.
  - Leaves the output register untouched.
  - Forces in_ready=0 that cycle; flush has priority over accept.
- Back-to-back: with out_ready=1 and single-cycle ops, throughput is 1 op/cycle.

Optional Feature:
- Macro EX_STALL_PERF_EN.
- Defined: adds output stall_cycles (32 bits) and input perf_clr.
  - stall_cycles increments each cycle state==EXEC & alu_stall, or state==HOLD.
  - Saturates at 0xFFFFFFFF.
  - Cleared by reset or perf_clr; perf_clr wins over increment.
- Undefined: ports and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package/defines: state encoding (IDLE=2'd0, EXEC=2'd1, HOLD=2'd2), ALU_OP_WID, op-bit indices for mul/div groups.
- No sub-module required. The perf counter stays inline under the macro.

Test Plan:
- Reset mid-EXEC with a divide pending: rstn low -> out_valid=0, alu_op=0, in_ready=1 immediately, asynchronously.
- ADD 5+7, out_ready=1 -> out_valid next cycle, out_result=12. Ten back-to-back ADDs -> 10 results in 10 consecutive cycles.
- MUL 0xFFFFFFFF*2 (op bit 12) -> alu_op held 2 cycles; out_result=0xFFFFFFFE 2 cycles after accept; in_ready=0 during stall.
- DIV 100/7 with alu_stall held 10 cycles -> operands constant throughout; out_result=14 the cycle after stall falls.
- out_ready=0 with out_valid=1 when SUB 9-4 completes -> state HOLD, alu_op=0. Then out_ready=1 -> first result drains, out_result=5 next, new op accepted the same cycle.
- flush during a DIV stall -> IDLE next cycle; the old result never appears; the prior out_valid result is unaffected. With EX_STALL_PERF_EN, stall_cycles counts the exact EXEC-stall plus HOLD cycles.

Source files
------------

// File: rtl/ex_alu_stage_pkg.sv
// Shared definitions for the execute-stage sequencer: state encoding,
// default widths and the one-hot op-bit groups used by the ALU.
package ex_alu_stage_pkg;

  localparam int DEF_ALU_OP_WID = 19;
  localparam int DEF_DEST_WID   = 5;
  localparam int DEF_PC_WID     = 32;
  localparam int XLEN           = 32;

  // One-hot op-bit positions on the ALU op bus.
  localparam int OP_ADD_BIT = 0;
  localparam int OP_SUB_BIT = 1;
  localparam int MUL_LSB    = 12;
  localparam int MUL_MSB    = 14;
  localparam int DIV_LSB    = 15;
  localparam int DIV_MSB    = 18;

  // IDLE: slot empty. EXEC: slot drives the ALU. HOLD: result latched
  // locally while the output register is still occupied.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } ex_state_e;

endpackage

// File: rtl/ex_alu_stage.sv
// Execute-stage sequencer between the issue register and the ALU.
// Holds operands stable across multi-cycle ALU stalls and registers the
// result toward memory/writeback.
// Optional macro EX_STALL_PERF_EN adds a saturating stall-cycle counter
// (ports perf_clr / stall_cycles).
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. valid, once raised, holds its payload until
// the transfer; ready may depend combinationally on the other side's state.
module ex_alu_stage
  import ex_alu_stage_pkg::*;
#(
  parameter int ALU_OP_WID = DEF_ALU_OP_WID,
  parameter int DEST_WID   = DEF_DEST_WID,
  parameter int PC_WID     = DEF_PC_WID
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_OP_WID-1:0] in_alu_op,
  input  logic [31:0]           in_src1,
  input  logic [31:0]           in_src2,
  input  logic [DEST_WID-1:0]   in_dest,
  input  logic [PC_WID-1:0]     in_pc,
  output logic [ALU_OP_WID-1:0] alu_op,
  output logic [31:0]           alu_src1,
  output logic [31:0]           alu_src2,
  input  logic [31:0]           alu_result,
  input  logic                  alu_stall,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_result,
  output logic [DEST_WID-1:0]   out_dest,
  output logic [PC_WID-1:0]     out_pc,
`ifdef EX_STALL_PERF_EN
  input  logic                  perf_clr,
  output logic [31:0]           stall_cycles,
`endif
  output ex_state_e             dbg_state
);

  ex_state_e             state_q, state_d;
  logic [ALU_OP_WID-1:0] slot_op_q, slot_op_d;
  logic [31:0]           slot_src1_q, slot_src1_d;
  logic [31:0]           slot_src2_q, slot_src2_d;
  logic [DEST_WID-1:0]   slot_dest_q, slot_dest_d;
  logic [PC_WID-1:0]     slot_pc_q, slot_pc_d;
  logic [31:0]           hold_result_q, hold_result_d;
  logic                  out_valid_q, out_valid_d;
  logic [31:0]           out_result_q, out_result_d;
  logic [DEST_WID-1:0]   out_dest_q, out_dest_d;
  logic [PC_WID-1:0]     out_pc_q, out_pc_d;

  logic out_free, done, accept, load_from_exec, load_from_hold;

  assign out_free = !out_valid_q || out_ready;
  assign done     = (state_q == ST_EXEC) && !alu_stall;
  // flush kills whatever is in the slot, so nothing may enter that cycle.
  assign in_ready = !flush && ((state_q == ST_IDLE) || (done && out_free) ||
                               ((state_q == ST_HOLD) && out_ready));
  assign accept   = in_valid && in_ready;
  // A flushed op must never reach the output register.
  assign load_from_exec = !flush && done && out_free;
  assign load_from_hold = !flush && (state_q == ST_HOLD) && out_ready;

  // The op is dropped as soon as EXEC is left: holding it past completion
  // would restart the ALU's multiply sequence.
  assign alu_op   = (state_q == ST_EXEC) ? slot_op_q : '0;
  assign alu_src1 = slot_src1_q;
  assign alu_src2 = slot_src2_q;

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_dest   = out_dest_q;
  assign out_pc     = out_pc_q;
  assign dbg_state  = state_q;

  // Next-state, slot, hold and output-register update.
  always_comb begin
    state_d       = state_q;
    slot_op_d     = slot_op_q;
    slot_src1_d   = slot_src1_q;
    slot_src2_d   = slot_src2_q;
    slot_dest_d   = slot_dest_q;
    slot_pc_d     = slot_pc_q;
    hold_result_d = hold_result_q;
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_dest_d    = out_dest_q;
    out_pc_d      = out_pc_q;

    // Drain first; a load in the same cycle overrides it.
    if (out_ready) out_valid_d = 1'b0;
    if (load_from_exec) begin
      out_valid_d  = 1'b1;
      out_result_d = alu_result;
      out_dest_d   = slot_dest_q;
      out_pc_d     = slot_pc_q;
    end
    if (load_from_hold) begin
      out_valid_d  = 1'b1;
      out_result_d = hold_result_q;
      out_dest_d   = slot_dest_q;
      out_pc_d     = slot_pc_q;
    end

    case (state_q)
      ST_IDLE: ;
      ST_EXEC: begin
        if (!alu_stall) begin
          if (out_free) begin
            state_d = ST_IDLE;
          end else begin
            state_d       = ST_HOLD;
            hold_result_d = alu_result;
          end
        end
      end
      ST_HOLD: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      state_d     = ST_EXEC;
      slot_op_d   = in_alu_op;
      slot_src1_d = in_src1;
      slot_src2_d = in_src2;
      slot_dest_d = in_dest;
      slot_pc_d   = in_pc;
    end

    if (flush) begin
      state_d       = ST_IDLE;
      slot_op_d     = '0;
      slot_src1_d   = '0;
      slot_src2_d   = '0;
      slot_dest_d   = '0;
      slot_pc_d     = '0;
      hold_result_d = '0;
    end
  end

  // State, slot, hold and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      slot_op_q     <= '0;
      slot_src1_q   <= '0;
      slot_src2_q   <= '0;
      slot_dest_q   <= '0;
      slot_pc_q     <= '0;
      hold_result_q <= '0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_dest_q    <= '0;
      out_pc_q      <= '0;
    end else begin
      state_q       <= state_d;
      slot_op_q     <= slot_op_d;
      slot_src1_q   <= slot_src1_d;
      slot_src2_q   <= slot_src2_d;
      slot_dest_q   <= slot_dest_d;
      slot_pc_q     <= slot_pc_d;
      hold_result_q <= hold_result_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_dest_q    <= out_dest_d;
      out_pc_q      <= out_pc_d;
    end
  end

`ifdef EX_STALL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Saturating count of stalled EXEC cycles plus HOLD cycles; clear wins.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (perf_clr) begin
      stall_cycles_d = '0;
    end else if ((((state_q == ST_EXEC) && alu_stall) || (state_q == ST_HOLD)) &&
                 (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) stall_cycles_q <= '0;
    else       stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed bench for ex_alu_stage. The bench plays the ALU (combinational
// result, stall driven by the test sequence) and the downstream consumer.
module tb_ex_alu_stage;
  import ex_alu_stage_pkg::*;

  localparam int OPW = DEF_ALU_OP_WID;
  localparam logic [OPW-1:0] OP_ADD = OPW'(1) << OP_ADD_BIT;
  localparam logic [OPW-1:0] OP_SUB = OPW'(1) << OP_SUB_BIT;
  localparam logic [OPW-1:0] OP_MUL = OPW'(1) << MUL_LSB;
  localparam logic [OPW-1:0] OP_DIV = OPW'(1) << DIV_LSB;

  logic           clk;
  logic           rstn;
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] in_alu_op;
  logic [31:0]    in_src1, in_src2;
  logic [4:0]     in_dest;
  logic [31:0]    in_pc;
  logic [OPW-1:0] alu_op;
  logic [31:0]    alu_src1, alu_src2;
  logic [31:0]    alu_result;
  logic           alu_stall;
  logic           out_valid;
  logic           out_ready;
  logic [31:0]    out_result;
  logic [4:0]     out_dest;
  logic [31:0]    out_pc;
  ex_state_e      dbg_state;
`ifdef EX_STALL_PERF_EN
  logic           perf_clr;
  logic [31:0]    stall_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  ex_alu_stage dut (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_alu_op  (in_alu_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_dest    (in_dest),
    .in_pc      (in_pc),
    .alu_op     (alu_op),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_result (alu_result),
    .alu_stall  (alu_stall),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_dest   (out_dest),
    .out_pc     (out_pc),
`ifdef EX_STALL_PERF_EN
    .perf_clr     (perf_clr),
    .stall_cycles (stall_cycles),
`endif
    .dbg_state  (dbg_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ALU stand-in: combinational result from the op the stage drives.
  always_comb begin
    alu_result = '0;
    if (alu_op[OP_ADD_BIT])             alu_result = alu_src1 + alu_src2;
    else if (alu_op[OP_SUB_BIT])        alu_result = alu_src1 - alu_src2;
    else if (|alu_op[MUL_MSB:MUL_LSB])  alu_result = alu_src1 * alu_src2;
    else if (|alu_op[DIV_MSB:DIV_LSB])  alu_result = (alu_src2 == 0) ? 32'hFFFF_FFFF
                                                                     : alu_src1 / alu_src2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard: every consumed result must match the oldest expected one.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("sb_result", out_result, exp_q.pop_front());
    end
  end

  // Drivers: inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [OPW-1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] dest, input logic [31:0] pc,
                       input logic [31:0] exp, input bit push);
    in_valid  = 1'b1;
    in_alu_op = op;
    in_src1   = a;
    in_src2   = b;
    in_dest   = dest;
    in_pc     = pc;
    #1;
    check("issue_in_ready", 32'(in_ready), 32'd1);
    if (push) exp_q.push_back(exp);
    step();
    in_valid = 1'b0;
  endtask

  task automatic perf_clear();
`ifdef EX_STALL_PERF_EN
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
`endif
  endtask

  initial begin
    rstn = 1'b1; flush = 1'b0; in_valid = 1'b0; in_alu_op = '0;
    in_src1 = '0; in_src2 = '0; in_dest = '0; in_pc = '0;
    alu_stall = 1'b0; out_ready = 1'b1;
`ifdef EX_STALL_PERF_EN
    perf_clr = 1'b0;
`endif
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_dest", 32'(out_dest), 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_alu_src1", alu_src1, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rstn = 1'b1;
    step();

    // ADD 5+7: result one cycle after accept.
    issue(OP_ADD, 32'd5, 32'd7, 5'd3, 32'h100, 32'd12, 1'b1);
    check("add_alu_op", 32'(alu_op), 32'(OP_ADD));
    step();
    check("add_out_valid", 32'(out_valid), 32'd1);
    check("add_out_result", out_result, 32'd12);
    check("add_out_dest", 32'(out_dest), 32'd3);
    check("add_out_pc", out_pc, 32'h100);
    step();
    check("add_drained", 32'(out_valid), 32'd0);

    // Ten back-to-back ADDs at one per cycle.
    for (int i = 0; i < 10; i++) begin
      in_valid  = 1'b1;
      in_alu_op = OP_ADD;
      in_src1   = 32'(i);
      in_src2   = 32'd100;
      in_dest   = 5'(i);
      in_pc     = 32'h200 + 32'(4 * i);
      exp_q.push_back(32'(i + 100));
      #1;
      check("b2b_in_ready", 32'(in_ready), 32'd1);
      step();
      if (i > 0) check("b2b_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    step();
    check("b2b_last_valid", 32'(out_valid), 32'd1);
    check("b2b_last_result", out_result, 32'd109);
    step();
    check("b2b_drained", 32'(out_valid), 32'd0);

    // MUL 0xFFFFFFFF*2 with one stall cycle: result 2 cycles after accept.
    issue(OP_MUL, 32'hFFFF_FFFF, 32'd2, 5'd4, 32'h300, 32'hFFFF_FFFE, 1'b1);
    alu_stall = 1'b1;
    #1;
    check("mul_alu_op_c1", 32'(alu_op), 32'(OP_MUL));
    check("mul_in_ready_stall", 32'(in_ready), 32'd0);
    step();
    alu_stall = 1'b0;
    check("mul_alu_op_c2", 32'(alu_op), 32'(OP_MUL));
    check("mul_src1_c2", alu_src1, 32'hFFFF_FFFF);
    check("mul_out_valid_c2", 32'(out_valid), 32'd0);
    step();
    check("mul_out_valid", 32'(out_valid), 32'd1);
    check("mul_out_result", out_result, 32'hFFFF_FFFE);
    check("mul_alu_op_after", 32'(alu_op), 32'd0);
    step();

    // DIV 100/7 with a 10-cycle stall: operands stable, result after stall.
    issue(OP_DIV, 32'd100, 32'd7, 5'd5, 32'h400, 32'd14, 1'b1);
    alu_stall = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("div_src1", alu_src1, 32'd100);
      check("div_src2", alu_src2, 32'd7);
      check("div_alu_op", 32'(alu_op), 32'(OP_DIV));
      check("div_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    alu_stall = 1'b0;
    check("div_out_valid_pre", 32'(out_valid), 32'd0);
    step();
    check("div_out_valid", 32'(out_valid), 32'd1);
    check("div_out_result", out_result, 32'd14);
    step();

    // HOLD: SUB completes while the output register is blocked.
    perf_clear();
    out_ready = 1'b0;
    issue(OP_ADD, 32'd1, 32'd2, 5'd6, 32'h500, 32'd3, 1'b1);
    issue(OP_SUB, 32'd9, 32'd4, 5'd7, 32'h504, 32'd5, 1'b1);
    check("hold_in_ready_blk", 32'(in_ready), 32'd0);
    step();
    check("hold_state", 32'(dbg_state), 32'(ST_HOLD));
    check("hold_alu_op", 32'(alu_op), 32'd0);
    check("hold_out_valid", 32'(out_valid), 32'd1);
    check("hold_out_result", out_result, 32'd3);
    step();
    check("hold_state_2", 32'(dbg_state), 32'(ST_HOLD));
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_alu_op = OP_ADD;
    in_src1   = 32'd20;
    in_src2   = 32'd22;
    in_dest   = 5'd8;
    in_pc     = 32'h508;
    exp_q.push_back(32'd42);
    #1;
    check("hold_in_ready_rel", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("hold_drain_result", out_result, 32'd5);
    check("hold_drain_dest", 32'(out_dest), 32'd7);
    check("hold_drain_valid", 32'(out_valid), 32'd1);
    check("hold_new_state", 32'(dbg_state), 32'(ST_EXEC));
    step();
    check("hold_next_result", out_result, 32'd42);
`ifdef EX_STALL_PERF_EN
    check("perf_hold_cycles", stall_cycles, 32'd2);
`endif
    step();
    check("hold_done", 32'(out_valid), 32'd0);

    // flush mid-DIV: slot dies, output register keeps its result.
    perf_clear();
    out_ready = 1'b0;
    issue(OP_ADD, 32'd8, 32'd8, 5'd9, 32'h600, 32'd16, 1'b1);
    issue(OP_DIV, 32'd50, 32'd5, 5'd10, 32'h604, 32'd10, 1'b0);
    alu_stall = 1'b1;
    step();
    step();
    check("flush_pre_state", 32'(dbg_state), 32'(ST_EXEC));
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_alu_op = OP_ADD;
    in_src1   = 32'd77;
    in_src2   = 32'd1;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_state", 32'(dbg_state), 32'(ST_IDLE));
    check("flush_alu_op", 32'(alu_op), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd1);
    check("flush_out_result", out_result, 32'd16);
    step();
    check("flush_out_kept", out_result, 32'd16);
    out_ready = 1'b1;
    issue(OP_ADD, 32'd1, 32'd1, 5'd11, 32'h608, 32'd2, 1'b1);
    check("flush_drained", 32'(out_valid), 32'd0);
    step();
    alu_stall = 1'b0;
    step();
    check("post_flush_valid", 32'(out_valid), 32'd1);
    check("post_flush_result", out_result, 32'd2);
`ifdef EX_STALL_PERF_EN
    check("perf_flush_cycles", stall_cycles, 32'd4);
`endif
    step();

    // Asynchronous reset while a divide is pending.
    out_ready = 1'b0;
    issue(OP_ADD, 32'd3, 32'd4, 5'd12, 32'h700, 32'd7, 1'b0);
    issue(OP_DIV, 32'd9, 32'd3, 5'd13, 32'h704, 32'd3, 1'b0);
    alu_stall = 1'b1;
    step();
    check("arst_pre_valid", 32'(out_valid), 32'd1);
    check("arst_pre_state", 32'(dbg_state), 32'(ST_EXEC));
    #2 rstn = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_alu_op", 32'(alu_op), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("arst_out_result", out_result, 32'd0);
    alu_stall = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    step();
    issue(OP_ADD, 32'd2, 32'd2, 5'd14, 32'h800, 32'd4, 1'b1);
    step();
    check("arst_recover_result", out_result, 32'd4);
    step();

    check("sb_all_consumed", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
